// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - load/count/status bundle for countdown_timer
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] d;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (output load, d, en, input q, busy, done, zero);
  modport slave  (input load, d, en, output q, busy, done, zero);
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with IDLE/RUN control and expiry pulse
module countdown_timer #(
  parameter int WIDTH       = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_if.slave   bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (bus.load) begin
      // A load always wins over a same-edge expiry, so no pulse here.
      cnt_d    = bus.d;
      reload_d = bus.d;
      state_d  = (bus.d != '0) ? S_RUN : S_IDLE;
    end else if (state_q == S_RUN && bus.en) begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
      end else if (cnt_q == WIDTH'(1)) begin
        done_d = 1'b1;
        if (AUTO_RELOAD != 0) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  // The companion ripple counter updates on the falling edge; stay aligned with it.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign bus.q    = cnt_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = done_q;
  assign bus.zero = (cnt_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer, one-shot and auto-reload builds
module tb_countdown_timer;

  typedef struct {
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       zero;
    int         id;
  } exp_t;

  logic clk;
  logic rst0, rst1;
  int   pass_cnt;
  int   total_cnt;
  int   step_id;
  exp_t sb0[$];
  exp_t sb1[$];

  countdown_timer_if #(.WIDTH(4)) if0 ();
  countdown_timer_if #(.WIDTH(4)) if1 ();

  countdown_timer #(.WIDTH(4), .AUTO_RELOAD(0)) dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (if0.slave)
  );

  countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int which, input exp_t e, input logic [3:0] aq,
                       input logic ab, input logic ad, input logic az);
    total_cnt++;
    if (aq === e.q && ab === e.busy && ad === e.done && az === e.zero) begin
      pass_cnt++;
    end else begin
      $display("FAIL dut%0d step %0d: got q=%0d busy=%b done=%b zero=%b, expected q=%0d busy=%b done=%b zero=%b",
               which, e.id, aq, ab, ad, az, e.q, e.busy, e.done, e.zero);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        check(0, e, if0.q, if0.busy, if0.done, if0.zero);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        check(1, e, if1.q, if1.busy, if1.done, if1.zero);
      end
    end
  end

  // Drive one edge's inputs and queue the state expected right after that edge.
  task automatic step(input int which, input logic rst, input logic ld, input logic [3:0] dv,
                      input logic e_n, input logic [3:0] eq, input logic eb, input logic ed,
                      input logic ez);
    exp_t x;
    x.q = eq; x.busy = eb; x.done = ed; x.zero = ez; x.id = step_id;
    step_id++;
    if (which == 0) begin
      rst0 = rst; if0.load = ld; if0.d = dv; if0.en = e_n;
      sb0.push_back(x);
    end else begin
      rst1 = rst; if1.load = ld; if1.d = dv; if1.en = e_n;
      sb1.push_back(x);
    end
    @(negedge clk);
    #3;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    step_id   = 0;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.load = 1'b0; if0.d = 4'd0; if0.en = 1'b0;
    if1.load = 1'b0; if1.d = 4'd0; if1.en = 1'b0;

    // one-shot: reset, then load 5 and count to zero
    step(0, 1, 0, 0, 0, 4'd0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 4'd0, 0, 0, 1);
    step(0, 0, 1, 5, 1, 4'd5, 1, 0, 0);
    for (int v = 4; v >= 1; v--) step(0, 0, 0, 0, 1, 4'(v), 1, 0, 0);
    step(0, 0, 0, 0, 1, 4'd0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 4'd0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 4'd0, 0, 0, 1);

    // pause with en low
    step(0, 0, 1, 6, 1, 4'd6, 1, 0, 0);
    step(0, 0, 0, 0, 1, 4'd5, 1, 0, 0);
    step(0, 0, 0, 0, 0, 4'd5, 1, 0, 0);
    step(0, 0, 0, 0, 0, 4'd5, 1, 0, 0);
    step(0, 0, 0, 0, 1, 4'd4, 1, 0, 0);
    step(0, 0, 0, 0, 1, 4'd3, 1, 0, 0);
    step(0, 0, 0, 0, 1, 4'd2, 1, 0, 0);
    step(0, 0, 0, 0, 1, 4'd1, 1, 0, 0);

    // load on the would-be expiry edge suppresses done
    step(0, 0, 1, 9, 1, 4'd9, 1, 0, 0);

    // load zero goes idle silently; idle ignores en
    step(0, 0, 1, 0, 1, 4'd0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 4'd0, 0, 0, 1);

    // reset aborts mid-run
    step(0, 0, 1, 4, 1, 4'd4, 1, 0, 0);
    step(0, 0, 0, 0, 1, 4'd3, 1, 0, 0);
    step(0, 0, 0, 0, 1, 4'd2, 1, 0, 0);
    step(0, 1, 0, 0, 1, 4'd0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 4'd0, 0, 0, 1);

    // reset beats load, then a normal run of 7
    step(0, 1, 1, 7, 1, 4'd0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 4'd0, 0, 0, 1);
    step(0, 0, 1, 7, 1, 4'd7, 1, 0, 0);
    for (int v = 6; v >= 1; v--) step(0, 0, 0, 0, 1, 4'(v), 1, 0, 0);
    step(0, 0, 0, 0, 1, 4'd0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 4'd0, 0, 0, 1);

    // auto-reload: period 3
    step(1, 1, 0, 0, 0, 4'd0, 0, 0, 1);
    step(1, 0, 1, 3, 1, 4'd3, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      case (k % 3)
        0: step(1, 0, 0, 0, 1, 4'd2, 1, 0, 0);
        1: step(1, 0, 0, 0, 1, 4'd1, 1, 0, 0);
        default: step(1, 0, 0, 0, 1, 4'd3, 1, 1, 0);
      endcase
    end
    // pause keeps the value, no pulse
    step(1, 0, 0, 0, 0, 4'd2, 1, 0, 0);

    // reload value 1: done on every enabled edge
    step(1, 0, 1, 1, 1, 4'd1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 4'd1, 1, 1, 0);
    step(1, 0, 0, 0, 1, 4'd1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 4'd1, 1, 0, 0);
    step(1, 0, 1, 0, 1, 4'd0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 4'd0, 0, 0, 1);

    @(negedge clk);
    #3;
    total_cnt++;
    if (sb0.size() == 0 && sb1.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0", sb0.size(), sb1.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
